// File: rtl/iob_nco_ctrl.sv
// IOb-native manager that brings up an NCO (soft reset, period, enable)
// and rewrites its period or disables it on command.
module iob_nco_ctrl #(
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned PERIOD_W       = 16,
  parameter int unsigned SOFTRESET_ADDR = 0,
  parameter int unsigned ENABLE_ADDR    = 1,
  parameter int unsigned PERIOD_ADDR    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  update_i,
  input  logic                  stop_i,
  input  logic [PERIOD_W-1:0]   period_i,
  output logic                  busy_o,
  output logic                  running_o,
  output logic                  done_o,
  output logic                  iob_valid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic [DATA_W-1:0]     iob_rdata_i,
  input  logic                  iob_rvalid_i,
  input  logic                  iob_ready_i
);

  localparam int unsigned StrbW    = DATA_W / 8;
  localparam int unsigned PerBytes = (PERIOD_W + 7) / 8;
  localparam int unsigned SrstOff  = SOFTRESET_ADDR % 4;
  localparam int unsigned EnOff    = ENABLE_ADDR % 4;
  localparam int unsigned PerOff   = PERIOD_ADDR % 4;

  if (DATA_W != 32) begin : g_bad_data_w
    $error("iob_nco_ctrl: DATA_W must be 32");
  end
  if (PerOff + PerBytes > 4) begin : g_bad_period_lane
    $error("iob_nco_ctrl: PERIOD register crosses a 32-bit word boundary");
  end

  typedef enum logic [2:0] {
    StIdle,
    StSrstHi,
    StSrstLo,
    StWrPer,
    StWrEn,
    StRun,
    StUpd,
    StDis
  } state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]    wstrb_q, wstrb_d;
  logic                busy_q, busy_d;
  logic                running_q, running_d;
  logic                done_q, done_d;
  logic                hs;
  logic                unused_in;

  assign unused_in = ^{iob_rdata_i, iob_rvalid_i};
  assign hs        = valid_q & iob_ready_i;

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          period_d = period_i;
          state_d  = StSrstHi;
        end
      end
      StSrstHi: if (hs) state_d = StSrstLo;
      StSrstLo: if (hs) state_d = StWrPer;
      StWrPer:  if (hs) state_d = StWrEn;
      StWrEn: begin
        if (hs) begin
          state_d = StRun;
          done_d  = 1'b1;
        end
      end
      StRun: begin
        if (stop_i) begin
          state_d = StDis;
        end else if (update_i) begin
          period_d = period_i;
          state_d  = StUpd;
        end
      end
      StUpd: begin
        if (hs) begin
          state_d = StRun;
          done_d  = 1'b1;
        end
      end
      StDis: begin
        if (hs) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    valid_d = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    wstrb_d = '0;
    unique case (state_d)
      StSrstHi: begin
        valid_d = 1'b1;
        addr_d  = ADDR_W'(SOFTRESET_ADDR);
        wdata_d = DATA_W'(1) << (8 * SrstOff);
        wstrb_d = StrbW'(1) << SrstOff;
      end
      StSrstLo: begin
        valid_d = 1'b1;
        addr_d  = ADDR_W'(SOFTRESET_ADDR);
        wstrb_d = StrbW'(1) << SrstOff;
      end
      StWrPer, StUpd: begin
        valid_d = 1'b1;
        addr_d  = ADDR_W'(PERIOD_ADDR);
        wdata_d = DATA_W'(period_d) << (8 * PerOff);
        wstrb_d = StrbW'((1 << PerBytes) - 1) << PerOff;
      end
      StWrEn: begin
        valid_d = 1'b1;
        addr_d  = ADDR_W'(ENABLE_ADDR);
        wdata_d = DATA_W'(1) << (8 * EnOff);
        wstrb_d = StrbW'(1) << EnOff;
      end
      StDis: begin
        valid_d = 1'b1;
        addr_d  = ADDR_W'(ENABLE_ADDR);
        wstrb_d = StrbW'(1) << EnOff;
      end
      default: ;
    endcase
    busy_d    = valid_d;
    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      period_q  <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      busy_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      busy_q    <= busy_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign iob_valid_o = valid_q;
  assign iob_addr_o  = addr_q;
  assign iob_wdata_o = wdata_q;
  assign iob_wstrb_o = wstrb_q;
  assign busy_o      = busy_q;
  assign running_o   = running_q;
  assign done_o      = done_q;

endmodule
